// File: rtl/morse_pkg.sv
// morse_pkg: shared symbol-FSM state encoding and token length constants.
package morse_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, OVF} state_e;
  localparam int MORSE_LEN_W = 3;
  localparam logic [MORSE_LEN_W-1:0] MORSE_MAX_LEN = MORSE_LEN_W'(5);
  localparam logic [MORSE_LEN_W-1:0] MORSE_SPACE_LEN = '0;
endpackage

// File: rtl/morse_token_slot.sv
// morse_token_slot: one-entry valid/ready token register with a saturating drop counter.
module morse_token_slot
  import morse_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [4:0]             push_code,
  input  logic [MORSE_LEN_W-1:0] push_len,
  input  logic                   drop_extra,
  input  logic                   char_ready,
  output logic                   free,
  output logic                   char_valid,
  output logic [4:0]             char_code,
  output logic [MORSE_LEN_W-1:0] char_len,
  output logic [DROP_W-1:0]      drop_cnt
);
  logic                   valid_q, valid_d;
  logic [4:0]             code_q, code_d;
  logic [MORSE_LEN_W-1:0] len_q, len_d;
  logic [DROP_W-1:0]      drop_q, drop_d;
  logic                   load, drop_ev;
  always_comb begin
    free    = !valid_q || char_ready;
    load    = push && free;
    drop_ev = (push && !free) || drop_extra;
    valid_d = load || (valid_q && !char_ready);
    code_d  = load ? push_code : code_q;
    len_d   = load ? push_len : len_q;
    drop_d  = (drop_ev && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      len_q   <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      len_q   <= len_d;
      drop_q  <= drop_d;
    end
  assign char_valid = valid_q;
  assign char_code  = code_q;
  assign char_len   = len_q;
  assign drop_cnt   = drop_q;
endmodule

// File: rtl/morse_symbol_controller.sv
// morse_symbol_controller: assembles dot/dash pulses into symbols and commits tokens on gaps.
// Optional MORSE_WG_SPACE_EN: word gaps additionally emit a single space token.
module morse_symbol_controller
  import morse_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   dot,
  input  logic                   dash,
  input  logic                   lg,
  input  logic                   wg,
  output logic [4:0]             sym_code,
  output logic [MORSE_LEN_W-1:0] sym_len,
  output logic                   ovf,
  output logic                   char_valid,
  input  logic                   char_ready,
  output logic [4:0]             char_code,
  output logic [MORSE_LEN_W-1:0] char_len,
  output logic [DROP_W-1:0]      drop_cnt
);
  state_e                 state_q, state_d;
  logic [4:0]             code_q, code_d;
  logic [MORSE_LEN_W-1:0] len_q, len_d;
  logic                   elem, gap, commit, free, space_load;
  always_comb begin
    elem    = dot ^ dash;
    gap     = lg || wg;
    commit  = gap && state_q == COLLECT;
    state_d = state_q;
    code_d  = code_q;
    len_d   = len_q;
    if (gap) begin
      state_d = IDLE;
      code_d  = '0;
      len_d   = '0;
    end
    // a gap closes the old symbol first, so a coincident element starts a new one
    if (elem) begin
      if (gap || state_q == IDLE) begin
        state_d = COLLECT;
        code_d  = {4'b0, dash};
        len_d   = MORSE_LEN_W'(1);
      end else if (state_q == COLLECT && len_q == MORSE_MAX_LEN) begin
        state_d = OVF;
      end else if (state_q == COLLECT) begin
        code_d[len_q] = dash;
        len_d         = len_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
    end
`ifdef MORSE_WG_SPACE_EN
  logic pend_q, pend_d, seen_q, seen_d, letter_load;
  always_comb begin
    space_load  = pend_q && free;
    letter_load = commit && free && !space_load;
    pend_d      = space_load ? 1'b0 : (pend_q || (wg && (seen_q || letter_load)));
    seen_d      = space_load ? 1'b0 : (seen_q || letter_load);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend_q <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      seen_q <= seen_d;
    end
`else
  assign space_load = 1'b0;
`endif
  morse_token_slot #(.DROP_W(DROP_W)) u_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (commit || space_load),
    .push_code  (space_load ? 5'b0 : code_q),
    .push_len   (space_load ? MORSE_SPACE_LEN : len_q),
    .drop_extra (space_load && commit),
    .char_ready (char_ready),
    .free       (free),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_len   (char_len),
    .drop_cnt   (drop_cnt)
  );
  assign sym_code = code_q;
  assign sym_len  = len_q;
  assign ovf      = state_q == OVF;
endmodule

// File: tb/tb_morse_symbol_controller.sv
// tb_morse_symbol_controller: directed self-checking bench for morse_symbol_controller.
module tb_morse_symbol_controller;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dot = 1'b0, dash = 1'b0, lg = 1'b0, wg = 1'b0, char_ready = 1'b0;
  logic [4:0] sym_code, char_code;
  logic [2:0] sym_len, char_len;
  logic       ovf, char_valid;
  logic [7:0] drop_cnt;
  int total = 0, bad = 0;

  morse_symbol_controller #(.DROP_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .dot(dot), .dash(dash), .lg(lg), .wg(wg),
    .sym_code(sym_code), .sym_len(sym_len), .ovf(ovf), .char_valid(char_valid),
    .char_ready(char_ready), .char_code(char_code), .char_len(char_len), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // inputs change on the falling edge; outputs seen here reflect the previous rising edge
  task automatic drive(input logic d, input logic a, input logic l, input logic w);
    @(negedge clk);
    {dot, dash, lg, wg} = {d, a, l, w};
  endtask

  task automatic test_reset();
    total++;
    if ({sym_code, sym_len, ovf, char_valid, char_code, char_len, drop_cnt} !== 26'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {sym_code, sym_len, ovf, char_valid, char_code, char_len, drop_cnt});
    end
    drive(0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  task automatic test_basic_token();
    char_ready = 1'b1;
    drive(0, 1, 0, 0); drive(1, 0, 0, 0); drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    total++;
    if (sym_len !== 3'd3 || sym_code !== 5'b00101) begin
      bad++; $display("FAIL basic_sym got=%b/%0d want=00101/3", sym_code, sym_len);
    end
    drive(0, 0, 0, 0);
    total++;
    if ({char_valid, char_code, char_len} !== {1'b1, 5'b00101, 3'd3}) begin
      bad++; $display("FAIL basic_token got=%b/%b/%0d want=1/00101/3", char_valid, char_code, char_len);
    end
    total++;
    if (sym_len !== 3'd0 || sym_code !== 5'd0) begin
      bad++; $display("FAIL basic_clear got=%b/%0d want=00000/0", sym_code, sym_len);
    end
    drive(0, 0, 0, 0);
    total++;
    if (char_valid !== 1'b0) begin
      bad++; $display("FAIL basic_one_cycle got=%b want=0", char_valid);
    end
  endtask

  task automatic test_both_ignored();
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 0);
    total++;
    if (sym_len !== 3'd0) begin
      bad++; $display("FAIL both_ignored got=%0d want=0", sym_len);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    total++;
    if (ovf !== 1'b0 || sym_len !== 3'd5) begin
      bad++; $display("FAIL ovf_at5 got=%b/%0d want=0/5", ovf, sym_len);
    end
    drive(0, 1, 0, 0);
    total++;
    if (ovf !== 1'b1 || sym_len !== 3'd5 || sym_code !== 5'd0) begin
      bad++; $display("FAIL ovf_set got=%b/%0d/%b want=1/5/00000", ovf, sym_len, sym_code);
    end
    drive(0, 0, 1, 0);
    total++;
    if (ovf !== 1'b1 || sym_code !== 5'd0) begin
      bad++; $display("FAIL ovf_freeze got=%b/%b want=1/00000", ovf, sym_code);
    end
    drive(0, 0, 0, 0);
    total++;
    if (ovf !== 1'b0 || sym_len !== 3'd0 || char_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      bad++; $display("FAIL ovf_discard got=%b/%0d/%b/%0d want=0/0/0/0", ovf, sym_len, char_valid, drop_cnt);
    end
  endtask

  task automatic test_backpressure();
    char_ready = 1'b0;
    drive(1, 0, 0, 0); drive(0, 0, 1, 0); drive(0, 1, 0, 0); drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    total++;
    if ({char_valid, char_code, char_len} !== {1'b1, 5'd0, 3'd1} || drop_cnt !== 8'd1) begin
      bad++; $display("FAIL bp_hold got=%b/%b/%0d drop=%0d want=1/00000/1 drop=1", char_valid, char_code, char_len, drop_cnt);
    end
    char_ready = 1'b1;
    drive(0, 0, 0, 0);
    total++;
    if (char_valid !== 1'b0 || drop_cnt !== 8'd1) begin
      bad++; $display("FAIL bp_transfer got=%b drop=%0d want=0 drop=1", char_valid, drop_cnt);
    end
  endtask

  task automatic test_gap_with_element();
    drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(0, 1, 1, 0);
    drive(0, 0, 0, 0);
    total++;
    if ({char_valid, char_code, char_len} !== {1'b1, 5'd0, 3'd2}) begin
      bad++; $display("FAIL gap_elem_token got=%b/%b/%0d want=1/00000/2", char_valid, char_code, char_len);
    end
    total++;
    if (sym_len !== 3'd1 || sym_code !== 5'b00001) begin
      bad++; $display("FAIL gap_elem_sym got=%b/%0d want=00001/1", sym_code, sym_len);
    end
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    total++;
    if ({char_valid, char_code, char_len} !== {1'b1, 5'b00001, 3'd1}) begin
      bad++; $display("FAIL gap_elem_next got=%b/%b/%0d want=1/00001/1", char_valid, char_code, char_len);
    end
  endtask

  task automatic test_word_gap();
    drive(1, 0, 0, 0); drive(0, 0, 0, 1); drive(0, 0, 0, 1);
    total++;
    if ({char_valid, char_code, char_len} !== {1'b1, 5'd0, 3'd1}) begin
      bad++; $display("FAIL wg_letter got=%b/%b/%0d want=1/00000/1", char_valid, char_code, char_len);
    end
    drive(0, 0, 0, 0);
`ifdef MORSE_WG_SPACE_EN
    total++;
    if ({char_valid, char_code, char_len} !== {1'b1, 5'd0, 3'd0}) begin
      bad++; $display("FAIL wg_space got=%b/%b/%0d want=1/00000/0", char_valid, char_code, char_len);
    end
`else
    total++;
    if (char_valid !== 1'b0) begin
      bad++; $display("FAIL wg_no_space got=%b want=0", char_valid);
    end
`endif
    drive(0, 0, 0, 0);
    total++;
    if (char_valid !== 1'b0 || drop_cnt !== 8'd1) begin
      bad++; $display("FAIL wg_single got=%b drop=%0d want=0 drop=1", char_valid, drop_cnt);
    end
  endtask

  task automatic test_async_reset();
    char_ready = 1'b0;
    drive(1, 0, 0, 0); drive(0, 0, 1, 0);
    drive(0, 1, 0, 0); drive(1, 0, 0, 0); drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    total++;
    if (char_valid !== 1'b1 || sym_len !== 3'd3) begin
      bad++; $display("FAIL rst_setup got=%b/%0d want=1/3", char_valid, sym_len);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({sym_code, sym_len, ovf, char_valid, char_code, char_len, drop_cnt} !== 26'd0) begin
      bad++; $display("FAIL rst_async got=%h want=0", {sym_code, sym_len, ovf, char_valid, char_code, char_len, drop_cnt});
    end
    drive(0, 0, 0, 0);
    reset_n = 1'b1;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    total++;
    if (sym_len !== 3'd1 || sym_code !== 5'd0 || char_valid !== 1'b0) begin
      bad++; $display("FAIL rst_resume got=%0d/%b/%b want=1/00000/0", sym_len, sym_code, char_valid);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic_token();
    test_both_ignored();
    test_overflow();
    test_backpressure();
    test_gap_with_element();
    test_word_gap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/morse_symbol_controller.md
# morse_symbol_controller

Sequencing controller between `morse_decoder` and the display path. Consumes single-cycle dot/dash/letter-gap/word-gap pulses, assembles elements into a symbol, and commits each completed symbol as one character token through a valid/ready output slot. Detects over-long symbols, counts tokens lost to back-pressure, and replaces the ad-hoc shift-register/counter glue at the application top level.

## Interface
- `DROP_W`, 8: width of the dropped-token counter.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `dot`  in  1  one-cycle pulse: dot element.
- `dash`  in  1  one-cycle pulse: dash element.
- `lg`  in  1  one-cycle pulse: letter gap.
- `wg`  in  1  one-cycle pulse: word gap.
- `sym_code`  out  5  live in-progress elements; bit i = element i (first element is bit 0), 1 = dash.
- `sym_len`  out  3  live element count, 0..5.
- `ovf`  out  1  current symbol exceeded 5 elements.
- `char_valid`  out  1  output token valid.
- `char_ready`  in  1  downstream accepts token.
- `char_code`  out  5  token elements; bits at index ≥ `char_len` are 0.
- `char_len`  out  3  token length 1..5; 0 = space token.
- `drop_cnt`  out  DROP_W  saturating count of tokens lost to a full slot.

## Operation
- States: IDLE (`sym_len`=0), COLLECT (1..5), OVF.
- Element event: exactly one of `dot`/`dash` high. Both high together are ignored.
- IDLE/COLLECT with an element event:
  - Write the element bit at index `sym_len`.
  - Increment `sym_len`.
- COLLECT at length 5 with an element event: go to OVF and set `ovf`=1. `sym_code`/`sym_len` freeze.
- OVF: further elements are ignored.
- Gap (`lg` or `wg`):
  - From COLLECT: commit {`sym_code`, `sym_len`} as a token.
  - From OVF: discard the symbol without a token or a drop count, and clear `ovf`.
  - From IDLE: no token.
  - In all cases clear `sym_code`/`sym_len` and go to IDLE.
- Gap and element in the same cycle: commit or discard the old symbol first. The element then becomes element 0 of the new symbol (`sym_len`=1).
- Output slot, one entry:
  - A commit loads the slot if it is empty or is transferring this cycle (`char_valid && char_ready`).
  - Otherwise the token is dropped and `drop_cnt` increments, saturating at all-ones.
- While `char_valid`=1, `char_code`/`char_len` are stable until transfer.
- Collection never stalls on back-pressure.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - slot empty;
  - space-pending flag clear.
- `sym_*` and `ovf` update the cycle after the event.
- `char_valid` rises the cycle after the gap pulse (1-cycle latency).
- On the transfer cycle, `char_valid` falls the next cycle unless a new token loads in the same cycle, in which case it stays high.
- `reset_n` low mid-symbol or with a pending token: everything clears immediately, including `drop_cnt`.

## Configuration
- `MORSE_WG_SPACE_EN` defined:
  - `wg` also sets a space-pending flag, but only if a letter token was loaded since the last space. This suppresses leading and repeated spaces.
  - The pending space loads as {`char_code`=0, `char_len`=0} on the first cycle the slot is free, and the flag then clears.
  - If a letter commit and a pending space contend for a free slot, the space loads and the letter is dropped (`drop_cnt`++).
  - Additional `wg` pulses while the flag is set have no effect.
- Undefined: `wg` behaves exactly as `lg`; no space tokens are produced.

## Structure
- Shared package `morse_pkg`:
  - state enum {IDLE, COLLECT, OVF};
  - `MORSE_MAX_LEN`=5;
  - `MORSE_LEN_W`=3;
  - `MORSE_SPACE_LEN`=0.
- One sub-module: `morse_token_slot`, the one-entry valid/ready register with the drop counter.
- Symbol FSM and space logic live in the top.

## Test plan
- dash, dot, dash, lg with `char_ready`=1 → one token, `char_code`=5'b00101, `char_len`=3, `char_valid` high for 1 cycle.
- Six dots then lg → `ovf`=1 after the 6th dot, no token, `ovf`=0 after lg, `drop_cnt`=0.
- `char_ready`=0; "dot,lg" then "dash,lg" → slot holds {00000,1}, `drop_cnt`=1. Raise ready → that token transfers, slot empty.
- lg in the same cycle as dash after two dots → token {00000,2}, then `sym_len`=1, `sym_code`=00001.
- `MORSE_WG_SPACE_EN`: dot, wg, wg with ready=1 → tokens {00000,1} then {00000,0}, exactly one space. Without the macro, only {00000,1}.
- Assert `reset_n` low with a token pending and `sym_len`=3 → all outputs 0 asynchronously. The next dot gives `sym_len`=1.
